sprite_rom_arbiter: RTL and testbench
=====================================

SPRITE_ROM_ARBITER -- requirements
Module: sprite_rom_arbiter

Interface
REQ-001 Parameter ADDR_W, default 8, meaning: shape-memory address width, {sprite id[7:4], row[3:0]}.
REQ-002 Parameter DATA_W, default 64, meaning: one shape row, 16 pixels x 4-bit colour code.
REQ-003 Parameter ROM_LAT, default 1, legal 1..3, meaning: cycles from rom_en to valid rom_data.
REQ-004 clk  input  1  single system clock, all state on rising edge.
REQ-005 reset  input  1  asynchronous, active-low reset.
REQ-006 req  input  4  per-requester fetch request, level, held until ack.
REQ-007 req_addr  input  4*ADDR_W  packed addresses, requester k at bits [k*ADDR_W +: ADDR_W].
REQ-008 ack  output  4  one-hot, one-cycle completion pulse.
REQ-009 rd_data  output  DATA_W  fetched row, valid in the ack cycle, held until the next capture.
REQ-010 grant_id  output  2  index of the requester currently or most recently served.
REQ-011 busy  output  1  high in every state except IDLE.
REQ-012 rom_addr  output  ADDR_W  shared shape-memory address, registered.
REQ-013 rom_en  output  1  shared shape-memory read strobe, one cycle per fetch.
REQ-014 rom_data  input  DATA_W  shape-memory read data.

Function
REQ-015 The FSM SHALL use states IDLE, ISSUE, WAIT and RESP only.
REQ-016 IDLE: with any eligible req, select a winner, latch its address and index, and go to ISSUE; otherwise stay in IDLE.
REQ-017 ISSUE: rom_en=1 and rom_addr=latched address for exactly one cycle, then go to WAIT.
REQ-018 WAIT: hold for ROM_LAT cycles; in the last WAIT cycle capture rom_data into rd_data, then go to RESP.
REQ-019 RESP: ack[grant_id]=1 for one cycle, update the priority pointer, then go to IDLE.
REQ-020 Latency: req sampled in IDLE at cycle T gives rom_en at T+1, capture at T+1+ROM_LAT and ack at T+2+ROM_LAT; ROM_LAT=1 gives ack at T+3.
REQ-021 Throughput: one fetch per 3+ROM_LAT cycles, with no back-to-back ISSUE.
REQ-022 Round-robin: the search starts at (last granted + 1) mod 4 and takes the first asserted req.
REQ-023 On the first IDLE cycle after RESP, the just-acked requester's req SHALL be masked, so a still-high req is not re-granted.
REQ-024 req or req_addr changes after the grant SHALL NOT affect the in-flight fetch.
REQ-025 A req dropped before its ack SHALL still complete; ack still pulses and is ignored.
REQ-026 rom_en SHALL be low outside ISSUE, and ack SHALL be all zeros outside RESP.
REQ-027 Simultaneous requests: exactly one winner per IDLE decision; losers wait, with no loss or duplication.
REQ-028 Starvation bound: any held req SHALL be acked within 4*(3+ROM_LAT)+1 cycles (round-robin build).

Reset
REQ-029 reset low SHALL immediately force IDLE, ack=0, rom_en=0, busy=0, rom_addr=0, rd_data=0, grant_id=0, mask cleared and pointer=3, so req[0] is searched first.
REQ-030 reset asserted mid-fetch SHALL abort the fetch with no ack; after release, arbitration restarts from IDLE.

Configuration
REQ-031 Macro SPRITE_ARB_FIXED_PRIO_EN defined: fixed priority with req[0] highest and req[3] lowest; the pointer is unused, and REQ-023 masking and the REQ-028 bound do not apply.
REQ-032 Macro SPRITE_ARB_FIXED_PRIO_EN undefined: round-robin per REQ-022, REQ-023 and REQ-028.

Verification
REQ-033 Single request: ROM_LAT=1, req=0001, addr0=0x23, request at T -> rom_en at T+1 with rom_addr=0x23; ack=0001 at T+3 with rd_data=ROM[0x23].
REQ-034 All four requesting: req=1111 held continuously after reset -> ack order 0,1,2,3,0 at 4-cycle spacing; rom_en never on consecutive cycles.
REQ-035 Fixed priority: build with SPRITE_ARB_FIXED_PRIO_EN, req=1010 held -> requester 1 acked repeatedly and requester 3 never acked while req[1] stays high.
REQ-036 Reset mid-fetch: reset low during WAIT -> ack stays 0000, busy=0 and rom_en=0 immediately; a new req after release is acked at T+3.
REQ-037 Latency sweep and mask: ROM_LAT=3, req[2] held across its ack -> ack at T+5; requester 2 is not re-granted in the next IDLE cycle, then is re-granted if still held.

Source files
------------

// File: rtl/sprite_rom_arbiter_if.sv
// Bundle of the four requester ports and the shared shape-memory port.
// slave: arbiter side. master: requesters plus memory model side.
interface sprite_rom_arbiter_if #(
   parameter int unsigned ADDR_W = 8,
   parameter int unsigned DATA_W = 64
);
   logic [3:0]          req;
   logic [4*ADDR_W-1:0] req_addr;
   logic [3:0]          ack;
   logic [DATA_W-1:0]   rd_data;
   logic [1:0]          grant_id;
   logic                busy;
   logic [ADDR_W-1:0]   rom_addr;
   logic                rom_en;
   logic [DATA_W-1:0]   rom_data;

   modport slave (
      input  req, req_addr, rom_data,
      output ack, rd_data, grant_id, busy, rom_addr, rom_en
   );

   modport master (
      output req, req_addr, rom_data,
      input  ack, rd_data, grant_id, busy, rom_addr, rom_en
   );
endinterface

// File: rtl/sprite_rom_arbiter.sv
// Four-requester arbiter that shares one shape-memory read port (IDLE/ISSUE/WAIT/RESP).
// Define SPRITE_ARB_FIXED_PRIO_EN for fixed priority (req[0] highest); default is round-robin.
module sprite_rom_arbiter #(
   parameter int unsigned ADDR_W  = 8,
   parameter int unsigned DATA_W  = 64,
   parameter int unsigned ROM_LAT = 1
) (
   input logic                 clk,
   input logic                 reset,
   sprite_rom_arbiter_if.slave bus
);
   localparam int unsigned CNT_W = 2;

   typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

   state_t              state;
   logic [CNT_W-1:0]    wait_cnt;
   logic [1:0]          grant_q;
   logic [3:0]          ack_q;
   logic                busy_q;
   logic                rom_en_q;
   logic [ADDR_W-1:0]   rom_addr_q;
   logic [DATA_W-1:0]   data_q;

   logic [1:0]          win_c;
   logic                found_c;
   logic [ADDR_W-1:0]   win_addr_c;

`ifdef SPRITE_ARB_FIXED_PRIO_EN
   // Lowest index wins.
   always_comb begin
      win_c   = '0;
      found_c = 1'b0;
      for (int i = 3; i >= 0; i--) begin
         if (bus.req[i]) begin
            found_c = 1'b1;
            win_c   = 2'(i);
         end
      end
   end
`else
   logic [1:0] ptr;
   logic [3:0] mask;
   logic [3:0] elig_c;
   logic [1:0] idx_c;

   // Search from the requester after the last grant; the just-acked one is masked for one IDLE cycle.
   always_comb begin
      elig_c  = bus.req & ~mask;
      win_c   = '0;
      found_c = 1'b0;
      idx_c   = '0;
      for (int i = 0; i < 4; i++) begin
         idx_c = 2'(32'(ptr) + 32'(i) + 32'd1);
         if (!found_c && elig_c[idx_c]) begin
            found_c = 1'b1;
            win_c   = idx_c;
         end
      end
   end
`endif

   always_comb begin
      win_addr_c = '0;
      for (int k = 0; k < 4; k++) begin
         if (win_c == 2'(k)) win_addr_c = bus.req_addr[k*ADDR_W +: ADDR_W];
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state      <= IDLE;
         wait_cnt   <= '0;
         grant_q    <= '0;
         ack_q      <= '0;
         busy_q     <= 1'b0;
         rom_en_q   <= 1'b0;
         rom_addr_q <= '0;
         data_q     <= '0;
`ifndef SPRITE_ARB_FIXED_PRIO_EN
         ptr        <= 2'd3;
         mask       <= '0;
`endif
      end else begin
         ack_q    <= '0;
         rom_en_q <= 1'b0;
         case (state)
            IDLE: begin
`ifndef SPRITE_ARB_FIXED_PRIO_EN
               mask <= '0;
`endif
               if (found_c) begin
                  grant_q    <= win_c;
                  rom_addr_q <= win_addr_c;
                  rom_en_q   <= 1'b1;
                  busy_q     <= 1'b1;
                  state      <= ISSUE;
               end
            end
            ISSUE: begin
               wait_cnt <= CNT_W'(ROM_LAT - 1);
               state    <= WAIT;
            end
            WAIT: begin
               if (wait_cnt == '0) begin
                  data_q <= bus.rom_data;
                  ack_q  <= 4'b0001 << grant_q;
                  state  <= RESP;
               end else begin
                  wait_cnt <= wait_cnt - CNT_W'(1);
               end
            end
            RESP: begin
               busy_q <= 1'b0;
               state  <= IDLE;
`ifndef SPRITE_ARB_FIXED_PRIO_EN
               ptr    <= grant_q;
               mask   <= 4'b0001 << grant_q;
`endif
            end
            default: state <= IDLE;
         endcase
      end
   end

   assign bus.ack      = ack_q;
   assign bus.rd_data  = data_q;
   assign bus.grant_id = grant_q;
   assign bus.busy     = busy_q;
   assign bus.rom_addr = rom_addr_q;
   assign bus.rom_en   = rom_en_q;
endmodule

// File: tb/tb_sprite_rom_arbiter.sv
// Bench for sprite_rom_arbiter: one instance at ROM_LAT=1, one at ROM_LAT=3, scoreboarded acks.
module tb_sprite_rom_arbiter;
   localparam int unsigned ADDR_W = 8;
   localparam int unsigned DATA_W = 64;

   typedef struct packed {
      logic [1:0]  id;
      logic [63:0] data;
      int          cyc;
   } exp_t;

   logic clk = 1'b0;
   logic reset;
   int   cyc = 0;
   int   pass_cnt = 0;
   int   total = 0;
   exp_t sbq[$];
   logic [63:0] p1, p2;

   sprite_rom_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) b1 ();
   sprite_rom_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) b3 ();

   sprite_rom_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .ROM_LAT(1)) dut1 (
      .clk(clk), .reset(reset), .bus(b1.slave));
   sprite_rom_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .ROM_LAT(3)) dut3 (
      .clk(clk), .reset(reset), .bus(b3.slave));

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   function automatic logic [63:0] rom_f(input logic [7:0] a);
      return {8{a}} ^ 64'h0123_4567_89AB_CDEF;
   endfunction

   // Memory models: data valid exactly ROM_LAT cycles after rom_en, garbage otherwise.
   always @(posedge clk) begin
      b1.rom_data <= b1.rom_en ? rom_f(b1.rom_addr) : 64'hDEAD_BEEF_DEAD_BEEF;
      p1          <= b3.rom_en ? rom_f(b3.rom_addr) : 64'hBAD0_BAD0_BAD0_BAD0;
      p2          <= p1;
      b3.rom_data <= p2;
   end

   task automatic test_reset();
      reset = 1'b0;
      b1.req = '0; b1.req_addr = '0;
      b3.req = '0; b3.req_addr = '0;
      repeat (2) @(negedge clk);
      total++; if (b1.ack !== 4'b0000) $display("FAIL reset_ack got=%b exp=0000", b1.ack); else pass_cnt++;
      total++; if (b1.rom_en !== 1'b0) $display("FAIL reset_rom_en got=%b exp=0", b1.rom_en); else pass_cnt++;
      total++; if (b1.busy !== 1'b0) $display("FAIL reset_busy got=%b exp=0", b1.busy); else pass_cnt++;
      total++; if (b1.rom_addr !== 8'h00) $display("FAIL reset_rom_addr got=%h exp=00", b1.rom_addr); else pass_cnt++;
      total++; if (b1.rd_data !== 64'h0) $display("FAIL reset_rd_data got=%h exp=0", b1.rd_data); else pass_cnt++;
      total++; if (b1.grant_id !== 2'd0) $display("FAIL reset_grant_id got=%0d exp=0", b1.grant_id); else pass_cnt++;
      total++;
      if ({b3.ack, b3.rom_en, b3.busy, b3.rom_addr, b3.grant_id} !== 16'h0 || b3.rd_data !== 64'h0)
         $display("FAIL reset_lat3 got=%b%b%b%h%h exp=all zero", b3.ack, b3.rom_en, b3.busy, b3.rom_addr, b3.grant_id);
      else pass_cnt++;
      reset = 1'b1;
      @(negedge clk);
   endtask

   task automatic test_single();
      int t0; exp_t e; logic [3:0] exp_ack; logic prev_en; logic b2b;
      prev_en = 1'b0; b2b = 1'b0;
      b1.req_addr = 32'h0000_0023;
      b1.req = 4'b0001;
      t0 = cyc;
      sbq.push_back('{id: 2'd0, data: rom_f(8'h23), cyc: t0 + 3});
      for (int n = 0; n < 10; n++) begin
         @(negedge clk);
         if (cyc == t0 + 1) begin
            total++;
            if (b1.rom_en !== 1'b1 || b1.rom_addr !== 8'h23)
               $display("FAIL single_issue got=en%b/%h exp=en1/23", b1.rom_en, b1.rom_addr);
            else pass_cnt++;
            b1.req = 4'b0000;           // dropped and re-addressed mid-fetch
            b1.req_addr = 32'h0000_0099;
         end
         if (b1.rom_en && prev_en) b2b = 1'b1;
         prev_en = b1.rom_en;
         if (b1.ack !== 4'b0000) begin
            total++;
            if (sbq.size() == 0) $display("FAIL single_extra_ack got=%b exp=0000", b1.ack);
            else begin
               e = sbq.pop_front(); exp_ack = 4'b0001 << e.id;
               if (b1.ack !== exp_ack || b1.rd_data !== e.data || cyc !== e.cyc)
                  $display("FAIL single_ack got=%b/%h@%0d exp=%b/%h@%0d", b1.ack, b1.rd_data, cyc, exp_ack, e.data, e.cyc);
               else pass_cnt++;
            end
         end
      end
      total++; if (sbq.size() != 0) $display("FAIL single_missing got=%0d exp=0 pending", sbq.size()); else pass_cnt++;
      total++; if (b2b) $display("FAIL single_b2b got=1 exp=0"); else pass_cnt++;
      sbq.delete();
   endtask

   task automatic test_all_four();
      int t0; exp_t e; logic [3:0] exp_ack; logic prev_en; logic b2b;
      logic [7:0] addr [4];
      prev_en = 1'b0; b2b = 1'b0;
      addr[0] = 8'h31; addr[1] = 8'h42; addr[2] = 8'h53; addr[3] = 8'h64;
      reset = 1'b0;
      @(negedge clk);
      b1.req_addr = {addr[3], addr[2], addr[1], addr[0]};
      b1.req = 4'b1111;
      @(negedge clk);
      reset = 1'b1;
      t0 = cyc;
      for (int k = 0; k < 6; k++)
         sbq.push_back('{id: 2'(k % 4), data: rom_f(addr[k % 4]), cyc: t0 + 3 + 4 * k});
      for (int n = 0; n < 28; n++) begin
         @(negedge clk);
         if (cyc == t0 + 21) b1.req = 4'b0000;
         if (b1.rom_en && prev_en) b2b = 1'b1;
         prev_en = b1.rom_en;
         if (b1.ack !== 4'b0000) begin
            total++;
            if (sbq.size() == 0) $display("FAIL rr_extra_ack got=%b exp=0000", b1.ack);
            else begin
               e = sbq.pop_front(); exp_ack = 4'b0001 << e.id;
               if (b1.ack !== exp_ack || b1.rd_data !== e.data || cyc !== e.cyc)
                  $display("FAIL rr_ack got=%b/%h@%0d exp=%b/%h@%0d", b1.ack, b1.rd_data, cyc, exp_ack, e.data, e.cyc);
               else pass_cnt++;
            end
         end
      end
      total++; if (sbq.size() != 0) $display("FAIL rr_missing got=%0d exp=0 pending", sbq.size()); else pass_cnt++;
      total++; if (b2b) $display("FAIL rr_b2b got=1 exp=0"); else pass_cnt++;
      sbq.delete();
   endtask

   task automatic test_latency_mask();
      int t0; exp_t e; logic [3:0] exp_ack;
      @(negedge clk);
      b3.req_addr = 32'h00C4_0000;
      b3.req = 4'b0100;
      t0 = cyc;
      sbq.push_back('{id: 2'd2, data: rom_f(8'hC4), cyc: t0 + 5});
      sbq.push_back('{id: 2'd2, data: rom_f(8'hC4), cyc: t0 + 12});
      for (int n = 0; n < 16; n++) begin
         @(negedge clk);
         if (cyc == t0 + 7) begin
            total++;
            if (b3.rom_en !== 1'b0) $display("FAIL mask_no_regrant got=en%b exp=en0", b3.rom_en); else pass_cnt++;
         end
         if (cyc == t0 + 8) begin
            total++;
            if (b3.rom_en !== 1'b1 || b3.grant_id !== 2'd2)
               $display("FAIL mask_regrant got=en%b/id%0d exp=en1/id2", b3.rom_en, b3.grant_id);
            else pass_cnt++;
            b3.req = 4'b0000;
         end
         if (b3.ack !== 4'b0000) begin
            total++;
            if (sbq.size() == 0) $display("FAIL lat3_extra_ack got=%b exp=0000", b3.ack);
            else begin
               e = sbq.pop_front(); exp_ack = 4'b0001 << e.id;
               if (b3.ack !== exp_ack || b3.rd_data !== e.data || cyc !== e.cyc)
                  $display("FAIL lat3_ack got=%b/%h@%0d exp=%b/%h@%0d", b3.ack, b3.rd_data, cyc, exp_ack, e.data, e.cyc);
               else pass_cnt++;
            end
         end
      end
      total++; if (sbq.size() != 0) $display("FAIL lat3_missing got=%0d exp=0 pending", sbq.size()); else pass_cnt++;
      sbq.delete();
   endtask

   task automatic test_fixed_prio();
      int t0; exp_t e; logic [3:0] exp_ack;
      @(negedge clk);
      b1.req_addr = 32'h3D00_1B00;
      b1.req = 4'b1010;
      t0 = cyc;
      for (int k = 0; k < 3; k++)
         sbq.push_back('{id: 2'd1, data: rom_f(8'h1B), cyc: t0 + 3 + 4 * k});
      for (int n = 0; n < 16; n++) begin
         @(negedge clk);
         if (cyc == t0 + 9) b1.req = 4'b0000;
         if (b1.ack !== 4'b0000) begin
            total++;
            if (sbq.size() == 0) $display("FAIL fixed_extra_ack got=%b exp=0000", b1.ack);
            else begin
               e = sbq.pop_front(); exp_ack = 4'b0001 << e.id;
               if (b1.ack !== exp_ack || b1.rd_data !== e.data || cyc !== e.cyc)
                  $display("FAIL fixed_ack got=%b/%h@%0d exp=%b/%h@%0d", b1.ack, b1.rd_data, cyc, exp_ack, e.data, e.cyc);
               else pass_cnt++;
            end
         end
      end
      total++; if (sbq.size() != 0) $display("FAIL fixed_missing got=%0d exp=0 pending", sbq.size()); else pass_cnt++;
      sbq.delete();
   endtask

   task automatic test_reset_mid();
      int t0; exp_t e; logic [3:0] exp_ack; logic stray;
      stray = 1'b0;
      @(negedge clk);
      b1.req_addr = 32'h0000_0077;
      b1.req = 4'b0001;
      repeat (2) @(negedge clk);
      total++; if (b1.busy !== 1'b1) $display("FAIL midrst_busy_before got=%b exp=1", b1.busy); else pass_cnt++;
      reset = 1'b0;
      b1.req = 4'b0000;
      #1;
      total++;
      if (b1.ack !== 4'b0000 || b1.busy !== 1'b0 || b1.rom_en !== 1'b0)
         $display("FAIL midrst_immediate got=ack%b/busy%b/en%b exp=ack0000/busy0/en0", b1.ack, b1.busy, b1.rom_en);
      else pass_cnt++;
      @(negedge clk);
      reset = 1'b1;
      for (int n = 0; n < 4; n++) begin
         @(negedge clk);
         if (b1.ack !== 4'b0000 || b1.rom_en !== 1'b0) stray = 1'b1;
      end
      total++; if (stray) $display("FAIL midrst_aborted got=activity exp=none"); else pass_cnt++;
      b1.req_addr = 32'h0000_005C;
      b1.req = 4'b0001;
      t0 = cyc;
      sbq.push_back('{id: 2'd0, data: rom_f(8'h5C), cyc: t0 + 3});
      for (int n = 0; n < 8; n++) begin
         @(negedge clk);
         if (cyc == t0 + 1) b1.req = 4'b0000;
         if (b1.ack !== 4'b0000) begin
            total++;
            if (sbq.size() == 0) $display("FAIL midrst_extra_ack got=%b exp=0000", b1.ack);
            else begin
               e = sbq.pop_front(); exp_ack = 4'b0001 << e.id;
               if (b1.ack !== exp_ack || b1.rd_data !== e.data || cyc !== e.cyc)
                  $display("FAIL midrst_ack got=%b/%h@%0d exp=%b/%h@%0d", b1.ack, b1.rd_data, cyc, exp_ack, e.data, e.cyc);
               else pass_cnt++;
            end
         end
      end
      total++; if (sbq.size() != 0) $display("FAIL midrst_missing got=%0d exp=0 pending", sbq.size()); else pass_cnt++;
      sbq.delete();
   endtask

   initial begin
      test_reset();
      test_single();
`ifndef SPRITE_ARB_FIXED_PRIO_EN
      test_all_four();
      test_latency_mask();
`else
      test_fixed_prio();
`endif
      test_reset_mid();
      $display("%0d/%0d checks passed", pass_cnt, total);
      $finish;
   end
endmodule
